// File: rtl/square_motion_ctrl_pkg.sv
// rtl/square_motion_ctrl_pkg.sv - shared timing constants and controller state codes
package square_motion_ctrl_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int SQ_SIZE_DEF  = 32;
    localparam int POS_W        = 11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                   input logic [POS_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/square_motion_ctrl_if.sv
// rtl/square_motion_ctrl_if.sv - valid/ready config port for the motion controller
interface square_motion_ctrl_if #(
    parameter int STEP_W = 4,
    parameter int DIV_W  = 4
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [10:0]       cfg_x;
    logic [10:0]       cfg_y;
    logic [STEP_W-1:0] cfg_dx;
    logic [STEP_W-1:0] cfg_dy;
    logic [DIV_W-1:0]  cfg_div;

    modport master (output cfg_valid, cfg_x, cfg_y, cfg_dx, cfg_dy, cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, cfg_x, cfg_y, cfg_dx, cfg_dy, cfg_div, output cfg_ready);
endinterface

// File: rtl/square_motion_ctrl_frame_tick_gen.sv
// rtl/square_motion_ctrl_frame_tick_gen.sv - one-cycle pulse at the first hc==0/vc==V_ACTIVE cycle
module square_motion_ctrl_frame_tick_gen #(
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] hc,
    input  logic [CNT_W-1:0] vc,
    output logic             tick_rise,
    output logic             frame_tick
);
    logic cond_d, cond_q;
    logic tick_d, tick_q;

    // tick_rise is the combinational edge so state can update on the same edge the pulse is registered
    always_comb begin
        cond_d = (hc == '0) && (vc == CNT_W'(V_ACTIVE));
        tick_d = cond_d && !cond_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cond_q <= cond_d;
            tick_q <= tick_d;
        end
    end

    assign tick_rise  = tick_d;
    assign frame_tick = tick_q;
endmodule

// File: rtl/square_motion_ctrl.sv
// rtl/square_motion_ctrl.sv - frame-synchronous bouncing-square position controller
module square_motion_ctrl
    import square_motion_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int SQ_SIZE  = SQ_SIZE_DEF,
    parameter int STEP_W   = 4,
    parameter int DIV_W    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [POS_W-1:0]         hc,
    input  logic [POS_W-1:0]         vc,
    input  logic                     run,
    square_motion_ctrl_if.slave      cfg,
    output logic [POS_W-1:0]         sq_x,
    output logic [POS_W-1:0]         sq_y,
    output logic                     frame_tick,
    output logic                     moving
);
    localparam int VEL_W = STEP_W + 1;
    localparam logic [POS_W-1:0] XMAX = POS_W'(H_ACTIVE - SQ_SIZE);
    localparam logic [POS_W-1:0] YMAX = POS_W'(V_ACTIVE - SQ_SIZE);
    localparam logic [POS_W-1:0] X0   = POS_W'((H_ACTIVE - SQ_SIZE) / 2);
    localparam logic [POS_W-1:0] Y0   = POS_W'((V_ACTIVE - SQ_SIZE) / 2);

    typedef struct packed {
        logic [POS_W-1:0]        pos;
        logic signed [VEL_W-1:0] vel;
    } axis_t;

    // One extra velocity bit so that negating the most negative step stays representable
    function automatic axis_t step_axis(input logic [POS_W-1:0] pos,
                                        input logic signed [VEL_W-1:0] vel,
                                        input logic [POS_W-1:0] lim);
        axis_t r;
        logic signed [POS_W:0] nx;
        nx    = $signed({1'b0, pos}) + $signed({{(POS_W+1-VEL_W){vel[VEL_W-1]}}, vel});
        r.pos = nx[POS_W-1:0];
        r.vel = vel;
        if (nx < 0) begin
            r.pos = '0;
            r.vel = -vel;
        end else if (nx > $signed({1'b0, lim})) begin
            r.pos = lim;
            r.vel = -vel;
        end
        return r;
    endfunction

    logic tick_rise;
    logic [POS_W-1:0] x_d, x_q, y_d, y_q, px_d, px_q, py_d, py_q;
    logic signed [VEL_W-1:0] dx_d, dx_q, dy_d, dy_q;
    logic [STEP_W-1:0] pdx_d, pdx_q, pdy_d, pdy_q;
    logic [DIV_W-1:0] div_d, div_q, pdiv_d, pdiv_q, cnt_d, cnt_q;
    logic [0:0] state_d, state_q;
    logic pend_d, pend_q;
    axis_t ax, ay;

    square_motion_ctrl_frame_tick_gen #(.V_ACTIVE(V_ACTIVE), .CNT_W(POS_W)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .hc         (hc),
        .vc         (vc),
        .tick_rise  (tick_rise),
        .frame_tick (frame_tick)
    );

    always_comb begin
        x_d = x_q;   y_d = y_q;   dx_d = dx_q;   dy_d = dy_q;
        div_d = div_q;   cnt_d = cnt_q;   state_d = state_q;   pend_d = pend_q;
        px_d = px_q; py_d = py_q; pdx_d = pdx_q; pdy_d = pdy_q; pdiv_d = pdiv_q;
        ax = step_axis(x_q, dx_q, XMAX);
        ay = step_axis(y_q, dy_q, YMAX);
        if (tick_rise) begin
            state_d = run ? ST_RUN : ST_IDLE;
            // A pending config pre-empts any step due on this tick
            if (pend_q) begin
                x_d    = clamp_pos(px_q, XMAX);
                y_d    = clamp_pos(py_q, YMAX);
                dx_d   = {pdx_q[STEP_W-1], pdx_q};
                dy_d   = {pdy_q[STEP_W-1], pdy_q};
                div_d  = pdiv_q;
                cnt_d  = '0;
                pend_d = 1'b0;
            end else if (state_q == ST_RUN && run) begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    x_d   = ax.pos;
                    dx_d  = ax.vel;
                    y_d   = ay.pos;
                    dy_d  = ay.vel;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
        end
        if (cfg.cfg_valid && !pend_q) begin
            px_d   = cfg.cfg_x;
            py_d   = cfg.cfg_y;
            pdx_d  = cfg.cfg_dx;
            pdy_d  = cfg.cfg_dy;
            pdiv_d = cfg.cfg_div;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= X0;          y_q <= Y0;
            dx_q <= VEL_W'(1);  dy_q <= VEL_W'(1);
            div_q <= '0;        cnt_q <= '0;
            state_q <= ST_IDLE; pend_q <= 1'b0;
            px_q <= '0;  py_q <= '0;  pdx_q <= '0;  pdy_q <= '0;  pdiv_q <= '0;
        end else begin
            x_q <= x_d;         y_q <= y_d;
            dx_q <= dx_d;       dy_q <= dy_d;
            div_q <= div_d;     cnt_q <= cnt_d;
            state_q <= state_d; pend_q <= pend_d;
            px_q <= px_d;  py_q <= py_d;  pdx_q <= pdx_d;  pdy_q <= pdy_d;  pdiv_q <= pdiv_d;
        end
    end

    assign cfg.cfg_ready = !pend_q;
    assign sq_x          = x_q;
    assign sq_y          = y_q;
    assign moving        = (state_q == ST_RUN);
endmodule

// File: tb/tb_square_motion_ctrl.sv
// tb/tb_square_motion_ctrl.sv - randomized bench with a behavioural model of the square controller
module tb_square_motion_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hc = 11'd5;
    logic [10:0] vc = 11'd5;
    logic        run = 1'b0;
    logic [10:0] sq_x, sq_y;
    logic        frame_tick, moving;

    square_motion_ctrl_if #(.STEP_W(4), .DIV_W(4)) cfg_if ();

    square_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .hc         (hc),
        .vc         (vc),
        .run        (run),
        .cfg        (cfg_if),
        .sq_x       (sq_x),
        .sq_y       (sq_y),
        .frame_tick (frame_tick),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tick_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic on positions and velocities
    int mx, my, mdx, mdy, mdiv, mcnt, nx, ny;
    int px, py, pdx, pdy, pdiv;
    bit mrun, mpend, mprev, mtick, cond, rise, acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mx = 304; my = 224; mdx = 1; mdy = 1; mdiv = 0; mcnt = 0;
            mrun = 0; mpend = 0; mprev = 0; mtick = 0;
        end else begin
            cond  = (hc == 11'd0) && (vc == 11'd480);
            rise  = cond && !mprev;
            mprev = cond;
            mtick = rise;
            acc   = (cfg_if.cfg_valid === 1'b1) && !mpend;
            if (rise) begin
                if (mpend) begin
                    mx = (px > 608) ? 608 : px;
                    my = (py > 448) ? 448 : py;
                    mdx = pdx; mdy = pdy; mdiv = pdiv; mcnt = 0; mpend = 0;
                end else if (mrun && run) begin
                    if (mcnt == mdiv) begin
                        mcnt = 0;
                        nx = mx + mdx;
                        ny = my + mdy;
                        if (nx < 0)        begin mx = 0;   mdx = -mdx; end
                        else if (nx > 608) begin mx = 608; mdx = -mdx; end
                        else mx = nx;
                        if (ny < 0)        begin my = 0;   mdy = -mdy; end
                        else if (ny > 448) begin my = 448; mdy = -mdy; end
                        else my = ny;
                    end else begin
                        mcnt++;
                    end
                end
                mrun = run;
            end
            if (acc) begin
                px = int'(cfg_if.cfg_x); py = int'(cfg_if.cfg_y);
                pdx = int'($signed(cfg_if.cfg_dx)); pdy = int'($signed(cfg_if.cfg_dy));
                pdiv = int'(cfg_if.cfg_div);
                mpend = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("model_sq_x", 32'(sq_x), mx);
            chk("model_sq_y", 32'(sq_y), my);
            chk("model_moving", 32'(moving), 32'(mrun));
            chk("model_frame_tick", 32'(frame_tick), 32'(mtick));
            chk("model_cfg_ready", 32'(cfg_if.cfg_ready), 32'(!mpend));
        end
        if (frame_tick === 1'b1) tick_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        int k;
        k = $urandom_range(1, 3);
        hc = 11'($urandom_range(1, 799)); vc = 11'($urandom_range(0, 524));
        cyc();
        hc = 11'd0; vc = 11'($urandom_range(0, 479));
        cyc();
        hc = 11'd0; vc = 11'd480;
        repeat (k) cyc();
        hc = 11'd3;
        cyc();
        cyc();
    endtask

    task automatic send_cfg(input int x, input int y, input int dx, input int dy, input int dv);
        bit ok;
        ok = 0;
        cfg_if.cfg_x = 11'(x); cfg_if.cfg_y = 11'(y);
        cfg_if.cfg_dx = 4'(dx); cfg_if.cfg_dy = 4'(dy); cfg_if.cfg_div = 4'(dv);
        cfg_if.cfg_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cfg_if.cfg_ready === 1'b1) begin
                cyc();
                ok = 1;
            end
        end
        cfg_if.cfg_valid = 1'b0;
        if (!ok) chk("cfg_accept_timeout", 0, 1);
    endtask

    task automatic poke_cfg();
        cfg_if.cfg_x = 11'($urandom); cfg_if.cfg_y = 11'($urandom);
        cfg_if.cfg_dx = 4'($urandom); cfg_if.cfg_dy = 4'($urandom); cfg_if.cfg_div = 4'($urandom_range(0, 2));
        cfg_if.cfg_valid = 1'b1;
        repeat (3) cyc();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int t0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_x = '0; cfg_if.cfg_y = '0; cfg_if.cfg_dx = '0; cfg_if.cfg_dy = '0; cfg_if.cfg_div = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_sq_x", 32'(sq_x), 304);
        chk("rst_sq_y", 32'(sq_y), 224);
        chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 1);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_frame_tick", 32'(frame_tick), 0);

        t0 = tick_cnt;
        frame(); frame();
        chk("idle_tick_count", 32'(tick_cnt - t0), 2);
        chk("idle_sq_x", 32'(sq_x), 304);
        chk("idle_sq_y", 32'(sq_y), 224);
        chk("idle_moving", 32'(moving), 0);

        run = 1'b1;
        frame();
        chk("run_moving", 32'(moving), 1);
        chk("run_enter_x", 32'(sq_x), 304);
        frame(); frame(); frame();
        chk("run3_x", 32'(sq_x), 307);
        chk("run3_y", 32'(sq_y), 227);

        send_cfg(605, 10, 4, -3, 0);
        frame(); chk("bnc_apply_x", 32'(sq_x), 605); chk("bnc_apply_y", 32'(sq_y), 10);
        frame(); chk("bnc1_x", 32'(sq_x), 608);      chk("bnc1_y", 32'(sq_y), 7);
        frame(); chk("bnc2_x", 32'(sq_x), 604);      chk("bnc2_y", 32'(sq_y), 4);
        frame(); chk("bnc3_x", 32'(sq_x), 600);      chk("bnc3_y", 32'(sq_y), 1);
        frame(); chk("bnc4_x", 32'(sq_x), 596);      chk("bnc4_y", 32'(sq_y), 0);

        send_cfg(100, 100, 1, 1, 2);
        frame(); chk("div_apply_x", 32'(sq_x), 100);
        frame(); frame(); chk("div_t2_x", 32'(sq_x), 100);
        frame(); chk("div_t3_x", 32'(sq_x), 101); chk("div_t3_y", 32'(sq_y), 101);
        frame(); frame(); frame(); frame();
        chk("div_t7_x", 32'(sq_x), 102); chk("div_t7_y", 32'(sq_y), 102);

        send_cfg(1000, 50, 1, 1, 0);
        cfg_if.cfg_x = 11'd10; cfg_if.cfg_y = 11'd10; cfg_if.cfg_valid = 1'b1;
        repeat (5) cyc();
        chk("pend_ready_low", 32'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
        frame();
        chk("clamp_x", 32'(sq_x), 608);
        chk("clamp_y", 32'(sq_y), 50);
        chk("ready_back", 32'(cfg_if.cfg_ready), 1);

        send_cfg(20, 20, 1, 1, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_sq_x", 32'(sq_x), 304);
        chk("arst_sq_y", 32'(sq_y), 224);
        chk("arst_cfg_ready", 32'(cfg_if.cfg_ready), 1);
        chk("arst_moving", 32'(moving), 0);
        cyc();
        reset = 1'b0;
        frame();
        chk("arst_nocfg_x", 32'(sq_x), 304);
        frame();
        chk("arst_step_x", 32'(sq_x), 305);
        chk("arst_step_y", 32'(sq_y), 225);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) run = ~run;
            if ($urandom_range(0, 2) == 0) begin
                if (cfg_if.cfg_ready === 1'b1)
                    send_cfg(int'($urandom_range(0, 1100)), int'($urandom_range(0, 700)),
                             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 2)));
                else
                    poke_cfg();
            end
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 4)) cyc();
            frame();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/square_motion_ctrl.md
Name: square_motion_ctrl

Overview:
Frame-synchronous controller that sequences the square pattern generator. It watches the sync generator's hc/vc counters and detects start of vertical blank. Once per programmable number of frames it steps the square's top-left position, bouncing off the active-area edges. It also accepts new position, velocity and rate settings over a valid/ready config port, applying them only at frame boundaries so a frame never tears mid-scan.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SQ_SIZE, 32, square edge length in pixels
STEP_W, 4, width of signed per-step velocity
DIV_W, 4, width of frame-divider setting

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
hc  in  11  horizontal counter from sync generator
vc  in  11  vertical counter from sync generator
run  in  1  enable motion; sampled only on frame_tick
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when valid&ready
cfg_x  in  11  new square x (top-left)
cfg_y  in  11  new square y (top-left)
cfg_dx  in  STEP_W  signed x step per update
cfg_dy  in  STEP_W  signed y step per update
cfg_div  in  DIV_W  frames between updates minus 1
sq_x  out  11  current square x, to pattern generator
sq_y  out  11  current square y, to pattern generator
frame_tick  out  1  one-cycle pulse at start of vblank
moving  out  1  high while in RUN

Behaviour:
- Clock: one clock, clk. Reset: reset is asynchronous and active-high.
- Reset values:
  - sq_x=(H_ACTIVE-SQ_SIZE)/2 (304); sq_y=(V_ACTIVE-SQ_SIZE)/2 (224).
  - dx=+1, dy=+1, div=0, frame counter=0.
  - frame_tick=0, cfg_ready=1, moving=0, state IDLE, no pending config.
- Frame detect:
  - cond = (hc==0 && vc==V_ACTIVE).
  - frame_tick is registered and pulses for exactly one clk on the first cycle after cond rises (edge-detected against the previous cycle).
  - Repeated cond cycles, e.g. from a pixel-enable divider, produce one tick only.
- Limits: XMAX=H_ACTIVE-SQ_SIZE (608), YMAX=V_ACTIVE-SQ_SIZE (448).
- Config handshake:
  - Accept when cfg_valid && cfg_ready. Capture all cfg_* into pending registers; cfg_ready drops the next cycle.
  - Pending config is applied on the next frame_tick: sq_x=min(cfg_x,XMAX), sq_y=min(cfg_y,YMAX), dx, dy, div loaded, frame counter cleared.
  - cfg_ready returns high the cycle after apply.
  - At most one pending config exists. cfg_valid while cfg_ready=0 is ignored, and the requester holds it.
  - Config applies in any state.
- States:
  - IDLE: position frozen. On frame_tick with run=1, go to RUN.
  - RUN: moving=1. On frame_tick with run=0, go to IDLE and take no step that tick.
  - On frame_tick with run=1: if frame counter==div, clear the counter and step; else increment the counter.
- Step arithmetic:
  - Compute in 12-bit signed: nx=sq_x+sext(dx).
  - If nx<0: sq_x=0, dx=-dx. If nx>XMAX: sq_x=XMAX, dx=-dx. Else sq_x=nx.
  - Same rule for y against YMAX.
  - dx=-8 negates to +8 using STEP_W+1 internal width. dx=0 holds the axis.
- Simultaneous events: pending config and a due step on the same tick means config wins (no step, counter cleared). The run transition evaluates on the same tick, independently of config.
- Latency: sq_x/sq_y change on the cycle frame_tick is high (registered, same edge as the pulse). They are stable for the entire active area.
- Reset mid-operation: all state returns to reset values immediately. Pending config is discarded.

Decomposition:
- Shared vga package: H_ACTIVE/V_ACTIVE timing constants, SQ_SIZE default, and a state enum (IDLE, RUN).
- One natural sub-module, frame_tick_gen: edge-detected vblank pulse from hc/vc. It is reusable by other per-frame controllers.
- Axis step/bounce logic is a function instantiated for x and y; no separate module.

Test Plan:
- Reset, then toggle hc/vc through 2 frames with run=0 -> sq=(304,224), frame_tick pulses once per frame, moving=0.
- run=1, div=0, dx=dy=+1 -> after 3 ticks sq=(307,227), moving=1 on the first tick.
- Config x=605, y=10, dx=+4, dy=-3, div=0 -> applied at the next tick with no step (605,10). Following ticks: (608,7) with dx flipped, then (604,4), then (600,1), then (596,0) with dy flipped.
- cfg_div=2 -> position steps only every 3rd frame_tick; the counter is verified across 7 ticks (2 steps).
- Second cfg_valid while pending -> cfg_ready=0 and the second config is ignored until ready returns. Config with x=1000 -> clamped to 608.
- Assert reset mid-RUN with a pending config -> outputs return to (304,224), cfg_ready=1, moving=0 with no clock edge required.
